// File: rtl/busdebugger_pkg.sv
// Shared constants and types for the bus debugger host command path:
// command letters, status bytes, decoder state and decoded operation.
package busdebugger_pkg;

  localparam logic [7:0] CMD_START   = 8'h53; // 'S'
  localparam logic [7:0] CMD_HALT    = 8'h48; // 'H'
  localparam logic [7:0] CMD_TRIGGER = 8'h54; // 'T'
  localparam logic [7:0] CMD_DUMP    = 8'h44; // 'D'
  localparam logic [7:0] CMD_ADDR    = 8'h41; // 'A'
  localparam logic [7:0] CMD_CLEAR   = 8'h43; // 'C'

  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  localparam logic [7:0] RESP_OK   = 8'h4B; // 'K'
  localparam logic [7:0] RESP_ERR  = 8'h3F; // '?'
  localparam logic [7:0] RESP_BUSY = 8'h42; // 'B'

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG,
    ST_EXEC,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_START,
    OP_HALT,
    OP_TRIGGER,
    OP_DUMP,
    OP_ADDR,
    OP_CLEAR,
    OP_ERROR
  } op_t;

  // Argument-less commands; 'A' and whitespace are handled by the caller.
  function automatic op_t decode_single(input logic [7:0] b);
    case (b)
      CMD_START:   return OP_START;
      CMD_HALT:    return OP_HALT;
      CMD_TRIGGER: return OP_TRIGGER;
      CMD_DUMP:    return OP_DUMP;
      CMD_CLEAR:   return OP_CLEAR;
      default:     return OP_ERROR;
    endcase
  endfunction

  function automatic logic is_whitespace(input logic [7:0] b);
    return (b == CHR_CR) || (b == CHR_LF) || (b == CHR_SPACE);
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble.
module hex_nibble_decode (
  input  logic [7:0] char_code,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // NOTE: every output gets a default before the branches, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b0;
    if (char_code >= 8'h30 && char_code <= 8'h39) begin
      nibble = 4'(char_code - 8'h30);
      is_hex = 1'b1;
    end else if (char_code >= 8'h41 && char_code <= 8'h46) begin
      nibble = 4'(char_code - 8'h37);
      is_hex = 1'b1;
    end else if (char_code >= 8'h61 && char_code <= 8'h66) begin
      nibble = 4'(char_code - 8'h57);
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/busdebugger_command_decoder.sv
// Host-to-debugger command parser: consumes USART bytes, drives the bus
// snooper controls and answers every command with one status byte.
module busdebugger_command_decoder
  import busdebugger_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16000000
) (
  input  logic                  comm_clock,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_available,
  input  logic                  rx_error,
  output logic                  rx_acknowledge,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  record_start,
  output logic                  record_trigger,
  output logic                  dump_start,
  input  logic                  dump_end,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic                  trigger_addr_valid
);

  localparam int DIGITS = ADDR_WIDTH / 4;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  state_t                state, state_next;
  op_t                   op, op_next;
  logic [ADDR_WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0]      digit_cnt, digit_cnt_next;
  logic [TMR_W-1:0]      timer, timer_next;
  logic                  ack_dly;
  logic                  ack_next;
  logic                  tx_valid_next;
  logic [7:0]            tx_data_next;
  logic                  record_start_next;
  logic [ADDR_WIDTH-1:0] trigger_addr_next;
  logic                  trigger_addr_valid_next;
  logic                  dump_busy, dump_busy_next, dump_busy_eff;
  logic [3:0]            nibble;
  logic                  is_hex;

  hex_nibble_decode u_hex (
    .char_code (rx_data),
    .nibble    (nibble),
    .is_hex    (is_hex)
  );

  // The receiver drops rx_available one cycle after seeing the ack, so the
  // cycle after an ack is skipped to avoid acknowledging the same byte twice.
  assign ack_next = ((state == ST_IDLE) || (state == ST_ARG)) &&
                    rx_available && !rx_acknowledge && !ack_dly;

  // A dump_end coinciding with a 'D' frees the snooper before the 'D' is judged.
  assign dump_busy_eff  = dump_busy && !dump_end;
  assign record_trigger = (state == ST_EXEC) && (op == OP_TRIGGER);
  assign dump_start     = (state == ST_EXEC) && (op == OP_DUMP) && !dump_busy_eff;

  always_comb begin
    state_next              = state;
    op_next                 = op;
    acc_next                = acc;
    digit_cnt_next          = digit_cnt;
    timer_next              = timer;
    tx_valid_next           = tx_valid;
    tx_data_next            = tx_data;
    record_start_next       = record_start;
    trigger_addr_next       = trigger_addr;
    trigger_addr_valid_next = trigger_addr_valid;
    dump_busy_next          = dump_busy_eff;

    unique case (state)
      ST_IDLE: begin
        if (rx_acknowledge) begin
          if (rx_error) begin
            op_next    = OP_ERROR;
            state_next = ST_EXEC;
          end else if (rx_data == CMD_ADDR) begin
            acc_next       = '0;
            digit_cnt_next = '0;
            timer_next     = TMR_W'(TIMEOUT);
            state_next     = ST_ARG;
          end else if (!is_whitespace(rx_data)) begin
            op_next    = decode_single(rx_data);
            state_next = ST_EXEC;
          end
        end
      end

      ST_ARG: begin
        if (rx_acknowledge) begin
          if (rx_error || !is_hex) begin
            op_next    = OP_ERROR;
            state_next = ST_EXEC;
          end else begin
            acc_next   = (acc << 4) | ADDR_WIDTH'(nibble);
            timer_next = TMR_W'(TIMEOUT);
            if (digit_cnt == CNT_W'(DIGITS - 1)) begin
              op_next    = OP_ADDR;
              state_next = ST_EXEC;
            end else begin
              digit_cnt_next = digit_cnt + CNT_W'(1);
            end
          end
        end else if (!ack_next) begin
          // A byte already being acknowledged wins over an expiring timer.
          if (timer == '0) begin
            op_next    = OP_ERROR;
            state_next = ST_EXEC;
          end else begin
            timer_next = timer - TMR_W'(1);
          end
        end
      end

      ST_EXEC: begin
        state_next    = ST_RESP;
        tx_valid_next = 1'b1;
        tx_data_next  = RESP_OK;
        case (op)
          OP_START:   record_start_next = 1'b1;
          OP_HALT:    record_start_next = 1'b0;
          OP_TRIGGER: ;
          OP_DUMP: begin
            if (dump_busy_eff) tx_data_next   = RESP_BUSY;
            else               dump_busy_next = 1'b1;
          end
          OP_ADDR: begin
            trigger_addr_next       = acc;
            trigger_addr_valid_next = 1'b1;
          end
          OP_CLEAR:   trigger_addr_valid_next = 1'b0;
          default:    tx_data_next = RESP_ERR;
        endcase
      end

      ST_RESP: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      op                 <= OP_ERROR;
      acc                <= '0;
      digit_cnt          <= '0;
      timer              <= '0;
      ack_dly            <= 1'b0;
      rx_acknowledge     <= 1'b0;
      tx_valid           <= 1'b0;
      tx_data            <= 8'h00;
      record_start       <= 1'b1;
      trigger_addr       <= '0;
      trigger_addr_valid <= 1'b0;
      dump_busy          <= 1'b0;
    end else begin
      state              <= state_next;
      op                 <= op_next;
      acc                <= acc_next;
      digit_cnt          <= digit_cnt_next;
      timer              <= timer_next;
      ack_dly            <= rx_acknowledge;
      rx_acknowledge     <= ack_next;
      tx_valid           <= tx_valid_next;
      tx_data            <= tx_data_next;
      record_start       <= record_start_next;
      trigger_addr       <= trigger_addr_next;
      trigger_addr_valid <= trigger_addr_valid_next;
      dump_busy          <= dump_busy_next;
    end
  end

endmodule
